// File: rtl/lab4_branch_gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor: FSM state,
// counter reset value, saturating counter step and PHT index hash.
package lab4_branch_gshare_pkg;

  localparam int unsigned PC_BITS      = 32;
  localparam int unsigned CTR_MAX_BITS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  // Weakly not-taken: 2^(bits-1) - 1.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_init(input int unsigned bits);
    return CTR_MAX_BITS'((32'd1 << (bits - 1)) - 32'd1);
  endfunction

  // Saturation is decided by the controller; this only applies the step.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_next(
    input logic [CTR_MAX_BITS-1:0] ctr,
    input logic                    inc,
    input logic                    dec
  );
    logic [CTR_MAX_BITS-1:0] nxt;
    nxt = ctr;
    if (inc) begin
      nxt = ctr + CTR_MAX_BITS'(1);
    end else if (dec) begin
      nxt = ctr - CTR_MAX_BITS'(1);
    end
    return nxt;
  endfunction

  // Word-aligned PC bits XOR zero-extended history, masked to the table size.
  function automatic logic [PC_BITS-1:0] gshare_idx(
    input logic [PC_BITS-1:0] pc,
    input logic [PC_BITS-1:0] ghr,
    input int unsigned        idx_bits
  );
    logic [PC_BITS-1:0] mask;
    mask = (PC_BITS'(1) << idx_bits) - PC_BITS'(1);
    return ((pc >> 2) ^ ghr) & mask;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_ctrl.sv
// IDLE/UPDATE control FSM for the gshare predictor: gates the update
// handshake and decides increment/decrement/hold for the latched entry.
module gshare_branch_predictor_ctrl
  import lab4_branch_gshare_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic update_en_i,
  input  logic update_taken_i,
  input  logic upper_reached_i,
  input  logic lower_reached_i,
  output logic update_rdy_o,
  output logic increment_entry_o,
  output logic decrement_entry_o,
  output logic update_ghr_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Update takes exactly one extra cycle, so UPDATE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (update_en_i) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    update_rdy_o      = 1'b0;
    increment_entry_o = 1'b0;
    decrement_entry_o = 1'b0;
    update_ghr_o      = 1'b0;
    case (state_q)
      IDLE: begin
        update_rdy_o = 1'b1;
      end
      UPDATE: begin
        increment_entry_o = update_taken_i  && !upper_reached_i;
        decrement_entry_o = !update_taken_i && !lower_reached_i;
        update_ghr_o      = 1'b1;
      end
      default: begin
        update_rdy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Parametrised gshare predictor datapath: PHT of saturating counters indexed by
// PC ^ GHR, zero-latency prediction. Optional macro GSHARE_PREDICT_BYPASS_EN
// forwards the in-flight counter value to a same-index prediction during UPDATE.
module gshare_branch_predictor
  import lab4_branch_gshare_pkg::*;
#(
  parameter int unsigned PHT_SIZE = 2048,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         predict_pc,
  output logic                predict_taken,
  input  logic                update_en,
  output logic                update_rdy,
  input  logic [31:0]         update_pc,
  input  logic                update_taken,
  output logic [GHR_BITS-1:0] ghr
);

  localparam int unsigned IDX_BITS = $clog2(PHT_SIZE);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0] pht_q [PHT_SIZE];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                taken_q, taken_d;

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [CTR_BITS-1:0] upd_ctr_nxt;
  logic [CTR_BITS-1:0] pred_ctr;
  logic                accept;
  logic                upper_reached;
  logic                lower_reached;
  logic                increment_entry;
  logic                decrement_entry;
  logic                update_ghr;

  gshare_branch_predictor_ctrl u_ctrl (
    .clk               (clk),
    .reset             (reset),
    .update_en_i       (update_en),
    .update_taken_i    (taken_q),
    .upper_reached_i   (upper_reached),
    .lower_reached_i   (lower_reached),
    .update_rdy_o      (update_rdy),
    .increment_entry_o (increment_entry),
    .decrement_entry_o (decrement_entry),
    .update_ghr_o      (update_ghr)
  );

  assign pred_idx = IDX_BITS'(gshare_idx(predict_pc, 32'(ghr_q), IDX_BITS));
  assign upd_idx  = IDX_BITS'(gshare_idx(update_pc, 32'(ghr_q), IDX_BITS));
  assign accept   = update_en && update_rdy;

  // Status of the entry being written back.
  assign upd_ctr       = pht_q[idx_q];
  assign upper_reached = (upd_ctr == CTR_MAX);
  assign lower_reached = (upd_ctr == '0);
  assign upd_ctr_nxt   = CTR_BITS'(ctr_next(4'(upd_ctr), increment_entry, decrement_entry));

  // Latch the resolved branch only when the handshake completes.
  always_comb begin
    idx_d   = idx_q;
    taken_d = taken_q;
    ghr_d   = ghr_q;
    if (accept) begin
      idx_d   = upd_idx;
      taken_d = update_taken;
    end
    if (update_ghr) begin
      ghr_d = GHR_BITS'({ghr_q, taken_q});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q   <= '0;
      idx_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      ghr_q   <= ghr_d;
      idx_q   <= idx_d;
      taken_q <= taken_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_SIZE; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (increment_entry || decrement_entry) begin
      pht_q[idx_q] <= upd_ctr_nxt;
    end
  end

`ifdef GSHARE_PREDICT_BYPASS_EN
  always_comb begin
    pred_ctr = pht_q[pred_idx];
    if (!update_rdy && (pred_idx == idx_q)) begin
      pred_ctr = upd_ctr_nxt;
    end
  end
`else
  assign pred_ctr = pht_q[pred_idx];
`endif

  assign predict_taken = pred_ctr[CTR_BITS-1];
  assign ghr           = ghr_q;

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Parametrised gshare global branch predictor, successor to the fixed 2048-entry global branch control unit in lab4_branch. Holds a pattern history table (PHT) of saturating counters and a global history register (GHR). The PHT is indexed by PC XOR GHR. Serves combinational taken/not-taken predictions to fetch and accepts resolved-branch updates from execute through a valid/ready handshake, with an explicit IDLE/UPDATE control FSM.

Parameters:
PHT_SIZE, 2048, number of PHT entries; power of two, at least 4; IDX_BITS = log2(PHT_SIZE)
CTR_BITS, 2, width of each saturating counter; 1 to 4
GHR_BITS, 8, global history length; 1 to IDX_BITS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
predict_pc  in  32  PC of the branch being fetched
predict_taken  out  1  prediction for predict_pc
update_en  in  1  update request valid
update_rdy  out  1  predictor can accept an update
update_pc  in  32  PC of the resolved branch
update_taken  in  1  resolved direction (1 = taken)
ghr  out  GHR_BITS  current global history (for debug and linetrace)

Behaviour:
- Index function: idx(pc) = pc[IDX_BITS+1:2] XOR zero-extended ghr. PC bits [1:0] are ignored.
- Prediction is combinational, zero latency: predict_taken = MSB of PHT[idx(predict_pc)].
- Reset (asynchronous, active-high):
  - FSM goes to IDLE, ghr = 0.
  - Every counter = 2^(CTR_BITS-1) - 1 (weakly not-taken; value 1 for CTR_BITS=2, 0 for CTR_BITS=1).
  - update_rdy = 1 and predict_taken = 0 immediately on reset.
- FSM, two states:
  - IDLE: update_rdy = 1. On update_en && update_rdy, latch idx(update_pc), computed with the current ghr, and latch update_taken; go to UPDATE. Otherwise stay in IDLE.
  - UPDATE: update_rdy = 0; update_en is ignored. On the clock edge, write the latched entry and set ghr = {ghr[GHR_BITS-2:0], taken}; return to IDLE unconditionally.
  - Throughput: one update every 2 cycles. The new counter value and new ghr are visible the cycle after UPDATE.
- Counter arithmetic, with decisions driven by status signals upper_reached (ctr == 2^CTR_BITS - 1) and lower_reached (ctr == 0):
  - taken and not upper_reached: increment.
  - not-taken and not lower_reached: decrement.
  - Otherwise hold (saturate).
  - The ghr always shifts, including when the counter saturates.
- GHR_BITS = 1: ghr becomes taken, with no shift.
- Predictions made during UPDATE see the pre-update table and the pre-update ghr (unless the optional feature is enabled).
- update_en asserted in IDLE with update_pc aliasing a predict_pc in the same cycle: no interaction; the prediction uses the current state.
- Reset asserted mid-UPDATE: the pending write is discarded and the reset values above apply.
- X on update_taken while update_en = 0 has no effect.

Optional Feature:
Macro GSHARE_PREDICT_BYPASS_EN.
- Defined: during UPDATE, if idx(predict_pc) equals the latched index, predict_taken = MSB of the post-update (next) counter value for that entry. The ghr used for indexing is still the pre-update value.
- Undefined: no forwarding; predict_taken reads the stored counter only.

Decomposition:
- Package lab4_branch_gshare_pkg holds:
  - the state enum (IDLE = 1'b0, UPDATE = 1'b1);
  - the counter-init function, the saturating next-counter function, and the index function.
- Sub-module gshare_branch_predictor_ctrl holds the FSM. It takes update_en, update_taken (latched), upper_reached and lower_reached, and produces update_rdy, increment_entry, decrement_entry and update_ghr.
- The top level holds the datapath: PHT array, ghr, latched index and taken bit, and the bypass mux.

Test Plan (PHT_SIZE=2048, CTR_BITS=2, GHR_BITS=8 unless noted):
1. Reset, then predict_pc=0x100 -> predict_taken=0, ghr=0x00, update_rdy=1.
2. Taken update, pc=0x100, ghr=0 -> next cycle update_rdy=0; after the UPDATE edge, ghr=0x01 and PHT[0x040]=2; predict_pc=0x100 now indexes 0x041 (weak, 0), while predict_pc=0x104 indexes 0x040 -> 1.
3. Saturate-high: reset ghr path with GHR_BITS=1, CTR_BITS=2; four taken updates to pc=0x200 -> counter stops at 3, no wrap to 0. Then one not-taken -> counter 2 and predict still 1.
4. Saturate-low: two not-taken updates at an entry holding 1 -> counter 0, not 3; ghr shifts 0 twice.
5. Handshake: hold update_en=1 continuously for 6 cycles -> exactly 3 updates accepted, update_rdy toggles 1,0,1,0,1,0, ghr shifts 3 times.
6. Reset mid-UPDATE: accept a taken update, assert reset during UPDATE -> ghr=0x00, entry stays 1, update_rdy=1. With GSHARE_PREDICT_BYPASS_EN, a same-index prediction during UPDATE, entry 1 going to 2 -> predict_taken=1 that cycle; without the macro -> 0.
